// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: shared encodings and do_data field positions for the DSP16 loop sequencer
package jtdsp16_pkg;
  typedef enum logic [1:0] {DO_IDLE, DO_LOAD, DO_REPLAY} do_state_t;
  localparam int DO_NI_MSB = 10;
  localparam int DO_NI_LSB = 7;
  localparam int DO_K_MSB = 6;
  localparam int DO_K_LSB = 0;
  localparam int DO_CACHE_DEPTH = 15;
endpackage

// File: rtl/jtdsp16_do_cache.sv
// jtdsp16_do_cache: loop body register file, synchronous write gated by cen, asynchronous read
module jtdsp16_do_cache #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   din,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   dout
);
  logic [15:0] mem [0:2**AW-1];
  always_ff @(posedge clk)
    if (cen && we) mem[waddr] <= din;
  assign dout = mem[raddr];
endmodule

// File: rtl/jtdsp16_do_seq.sv
// jtdsp16_do_seq: do/redo sequencer, captures the loop body on the first pass and replays it with the PC held
module jtdsp16_do_seq
  import jtdsp16_pkg::*;
#(
  parameter int CACHE_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        fetch_en,
  input  logic [15:0] instr_in,
  output logic [15:0] cache_dout,
  output logic        up_xcache,
  output logic        pc_hold,
  output logic        busy,
  output logic        fault
);
  do_state_t state, state_nx;
  logic [CACHE_AW-1:0] idx, idx_nx;
  logic [6:0] rem, rem_nx, k;
  logic [3:0] ni_len, ni_len_nx, ni;
  logic fault_nx, we, last;
  logic [15:0] rdata;
  assign ni = do_data[DO_NI_MSB:DO_NI_LSB];
  assign k = do_data[DO_K_MSB:DO_K_LSB];
  assign last = idx == CACHE_AW'(ni_len - 4'd1);
  jtdsp16_do_cache #(.AW(CACHE_AW)) u_cache (
    .clk(clk), .cen(cen), .we(we), .waddr(idx), .din(instr_in), .raddr(idx), .dout(rdata)
  );
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    rem_nx = rem;
    ni_len_nx = ni_len;
    we = 1'b0;
    fault_nx = do_start && (state != DO_IDLE || k == 7'd0 || (ni == 4'd0 && ni_len == 4'd0));
    if (state == DO_IDLE && do_start && !fault_nx) begin
      state_nx = ni != 4'd0 ? DO_LOAD : DO_REPLAY;
      ni_len_nx = ni != 4'd0 ? ni : ni_len;
      idx_nx = '0;
      rem_nx = ni != 4'd0 ? k - 7'd1 : k;
    end else if (state == DO_LOAD && fetch_en) begin
      we = 1'b1;
      idx_nx = last ? '0 : idx + CACHE_AW'(1);
      state_nx = !last ? DO_LOAD : rem == 7'd0 ? DO_IDLE : DO_REPLAY;
    end else if (state == DO_REPLAY && fetch_en) begin
      idx_nx = last ? '0 : idx + CACHE_AW'(1);
      rem_nx = last ? rem - 7'd1 : rem;
      state_nx = last && rem == 7'd1 ? DO_IDLE : DO_REPLAY;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= DO_IDLE;
      idx <= '0;
      rem <= '0;
      ni_len <= '0;
      fault <= 1'b0;
    end else if (cen) begin
      state <= state_nx;
      idx <= idx_nx;
      rem <= rem_nx;
      ni_len <= ni_len_nx;
      fault <= fault_nx;
    end
  assign up_xcache = state == DO_REPLAY;
  assign pc_hold = up_xcache;
  assign busy = state != DO_IDLE;
  assign cache_dout = up_xcache ? rdata : 16'd0;
endmodule

// File: tb/tb_jtdsp16_do_seq.sv
// tb_jtdsp16_do_seq: table-driven loop scenarios checked against a queue of expected issued words
module tb_jtdsp16_do_seq;
  logic clk = 0, rst = 1, cen = 0, do_start = 0, fetch_en = 0;
  logic [10:0] do_data = '0;
  logic [15:0] instr_in, cache_dout;
  logic up_xcache, pc_hold, busy, fault;
  logic [15:0] pc = '0;
  logic [3:0] bni = '0;
  int tests = 0, fails = 0;
  typedef struct { logic [15:0] w; logic src; } exp_t;
  typedef struct { logic [3:0] ni; logic [6:0] k; int gap; int inj; int rsta; } vec_t;
  exp_t q[$];
  logic [15:0] body[$];
  vec_t v[8];

  jtdsp16_do_seq dut (
    .clk(clk), .rst(rst), .cen(cen), .do_start(do_start), .do_data(do_data),
    .fetch_en(fetch_en), .instr_in(instr_in), .cache_dout(cache_dout),
    .up_xcache(up_xcache), .pc_hold(pc_hold), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;
  always_comb instr_in = 16'hA000 + pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, cache_dout, 0);
    chk({tag, "_xcache"}, up_xcache, 0);
    chk({tag, "_hold"}, pc_hold, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  task automatic run(input vec_t t);
    logic bad, adv;
    exp_t e;
    logic [15:0] w;
    int n, cyc;
    bad = t.k == 0 || (t.ni == 0 && bni == 0);
    @(negedge clk);
    cen = 1; fetch_en = 0; do_start = 1; do_data = {t.ni, t.k};
    @(posedge clk); #1;
    do_start = 0;
    chk("fault_start", fault, bad);
    chk("busy_start", busy, !bad);
    chk("xcache_start", up_xcache, t.ni == 0 && !bad);
    if (bad) begin
      @(negedge clk);
      @(posedge clk); #1;
      chk("fault_clear", fault, 0);
      chk("busy_after_fault", busy, 0);
      return;
    end
    if (t.ni != 0) begin
      bni = t.ni;
      body.delete();
      for (int i = 0; i < t.ni; i++) body.push_back(16'(16'hA000 + pc + 16'(i)));
      for (int i = 0; i < t.ni; i++) q.push_back('{body[i], 1'b0});
      for (int p = 1; p < t.k; p++)
        for (int i = 0; i < t.ni; i++) q.push_back('{body[i], 1'b1});
    end else begin
      for (int p = 0; p < t.k; p++)
        for (int i = 0; i < bni; i++) q.push_back('{body[i], 1'b1});
    end
    n = 0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      cen = t.gap != 0 ? (cyc % 4 != 1) : 1'b1;
      fetch_en = t.gap != 0 ? (cyc % 4 != 3) : 1'b1;
      adv = 0;
      if (n == t.rsta) begin
        rst = 1; cen = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_zero("rst_mid");
        q.delete();
        bni = 0;
        return;
      end
      if (cen && fetch_en) begin
        w = up_xcache ? cache_dout : instr_in;
        chk("q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("word", w, e.w);
          chk("src", up_xcache, e.src);
          adv = !e.src;
        end
        chk("hold_eq", pc_hold, up_xcache);
        if (!up_xcache) chk("dout_zero", cache_dout, 0);
        chk("busy", busy, 1);
        if (n == t.inj) begin do_start = 1; do_data = 11'h105; end
        n++;
      end
      @(posedge clk); #1;
      if (adv) pc++;
      if (do_start) begin
        do_start = 0;
        chk("fault_busy", fault, 1);
        chk("busy_kept", busy, 1);
      end
      if (!busy) break;
    end
    chk("no_timeout", cyc < 20000, 1);
    chk("q_empty", q.size(), 0);
    chk("idle_xcache", up_xcache, 0);
    chk("idle_fault", fault, 0);
  endtask

  initial begin
    v[0] = '{4'd3, 7'd4, 0, -1, -1};
    v[1] = '{4'd0, 7'd2, 0, -1, -1};
    v[2] = '{4'd2, 7'd1, 0, -1, -1};
    v[3] = '{4'd15, 7'd127, 1, -1, -1};
    v[4] = '{4'd3, 7'd0, 0, -1, -1};
    v[5] = '{4'd3, 7'd4, 0, 5, -1};
    v[6] = '{4'd3, 7'd4, 0, -1, 4};
    v[7] = '{4'd0, 7'd2, 0, -1, -1};
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    for (int i = 0; i < 8; i++) run(v[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
